// File: rtl/write_controller.sv
// ============================================================================
//  Module      : write_controller (with package write_controller_pkg)
//  Description : Register-write endpoint of the UART packet interface.
//                Takes the byte-wise packet stream from the deframer, pulls
//                out an 8-bit register address and a little-endian data word,
//                raises a one-cycle write strobe to the register bank and can
//                return a one-byte acknowledge packet on the TX stream.
//
//  Ports       : ipClk          - system clock, rising edge
//                ipReset        - asynchronous reset, active low
//                ipRxStream     - incoming packet bytes (taken when Valid=1)
//                ipTxReady      - TX framer takes opTxStream on this edge
//                opTxStream     - acknowledge packet stream
//                opWriteAddress - register address (held between writes)
//                opWriteData    - register data word (held between writes)
//                opWrite        - one-cycle write strobe
//                opError        - one-cycle pulse on a discarded packet
//                opBusy         - high in COMMIT and ACK; RX ignored then
//
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package write_controller_pkg;

    typedef struct packed {
        logic [7:0] Source;
        logic [7:0] Destination;
        logic [7:0] Length;
        logic       SoP;
        logic       EoP;
        logic       Valid;
        logic [7:0] Data;
    } UART_PACKET;

endpackage : write_controller_pkg

module write_controller
    import write_controller_pkg::*;
#(
    parameter logic [7:0] WRITE_DEST  = 8'h01,
    parameter int         DATA_LENGTH = 4,
    parameter bit         GEN_ACK     = 1'b1
) (
    input  logic                       ipClk,
    input  logic                       ipReset,
    input  UART_PACKET                 ipRxStream,
    input  logic                       ipTxReady,
    output UART_PACKET                 opTxStream,
    output logic [7:0]                 opWriteAddress,
    output logic [8*DATA_LENGTH-1:0]   opWriteData,
    output logic                       opWrite,
    output logic                       opError,
    output logic                       opBusy
);

    localparam int         WORD_W  = 8 * DATA_LENGTH;
    localparam int         CW      = $clog2(DATA_LENGTH + 1);
    // Header byte plus the data bytes.
    localparam logic [7:0] PKT_LEN = 8'(DATA_LENGTH + 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_DATA    = 3'd1;
    localparam logic [2:0] ST_DISCARD = 3'd2;
    localparam logic [2:0] ST_COMMIT  = 3'd3;
    localparam logic [2:0] ST_ACK     = 3'd4;

    logic [2:0]        state, state_nxt;
    logic [CW-1:0]     count, count_nxt;
    logic [CW-1:0]     lane;
    logic [WORD_W-1:0] word, word_nxt;
    logic [7:0]        addr, addr_nxt;
    logic [7:0]        src, src_nxt;
    logic              error_nxt;
    logic              eval_header;
    logic              write_nxt;
    logic              busy_nxt;
    logic [7:0]        write_address_nxt;
    logic [WORD_W-1:0] write_data_nxt;
    UART_PACKET        tx_nxt;

    logic hdr_for_us;
    logic hdr_match;
    logic hdr_bad_len;

    assign hdr_for_us  = ipRxStream.Valid & ipRxStream.SoP
                       & (ipRxStream.Destination == WRITE_DEST);
    assign hdr_match   = hdr_for_us & (ipRxStream.Length == PKT_LEN);
    assign hdr_bad_len = hdr_for_us & (ipRxStream.Length != PKT_LEN);

    // ------------------------------------------------------------------
    // State, datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            state          <= ST_IDLE;
            count          <= '0;
            word           <= '0;
            addr           <= '0;
            src            <= '0;
            opWrite        <= 1'b0;
            opError        <= 1'b0;
            opBusy         <= 1'b0;
            opWriteAddress <= '0;
            opWriteData    <= '0;
            opTxStream     <= '0;
        end else begin
            state          <= state_nxt;
            count          <= count_nxt;
            word           <= word_nxt;
            addr           <= addr_nxt;
            src            <= src_nxt;
            opWrite        <= write_nxt;
            opError        <= error_nxt;
            opBusy         <= busy_nxt;
            opWriteAddress <= write_address_nxt;
            opWriteData    <= write_data_nxt;
            opTxStream     <= tx_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and packet assembly
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        count_nxt   = count;
        word_nxt    = word;
        addr_nxt    = addr;
        src_nxt     = src;
        error_nxt   = 1'b0;
        eval_header = 1'b0;
        // count runs DATA_LENGTH..1, so the first data byte lands in lane 0.
        lane        = CW'(DATA_LENGTH) - count;

        case (state)
            ST_IDLE: begin
                eval_header = 1'b1;
            end

            ST_DATA: begin
                if (ipRxStream.Valid) begin
                    if (ipRxStream.SoP) begin
                        // Abort the current packet; the byte may start a new one.
                        error_nxt   = 1'b1;
                        state_nxt   = ST_IDLE;
                        eval_header = 1'b1;
                    end else begin
                        for (int i = 0; i < DATA_LENGTH; i++) begin
                            if (lane == CW'(i)) begin
                                word_nxt[8*i +: 8] = ipRxStream.Data;
                            end
                        end
                        count_nxt = count - CW'(1);
                        if (count == CW'(1)) begin
                            if (ipRxStream.EoP) begin
                                state_nxt = ST_COMMIT;
                            end else begin
                                error_nxt = 1'b1;
                                state_nxt = ST_DISCARD;
                            end
                        end else if (ipRxStream.EoP) begin
                            error_nxt = 1'b1;
                            state_nxt = ST_IDLE;
                        end
                    end
                end
            end

            ST_DISCARD: begin
                if (ipRxStream.Valid) begin
                    if (ipRxStream.SoP) begin
                        error_nxt   = 1'b1;
                        state_nxt   = ST_IDLE;
                        eval_header = 1'b1;
                    end else if (ipRxStream.EoP) begin
                        state_nxt = ST_IDLE;
                    end
                end
            end

            ST_COMMIT: begin
                state_nxt = GEN_ACK ? ST_ACK : ST_IDLE;
            end

            ST_ACK: begin
                if (ipTxReady) begin
                    state_nxt = ST_IDLE;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Shared header evaluation: IDLE, and the same-cycle restart after
        // an unexpected SoP in DATA or DISCARD.
        if (eval_header) begin
            if (hdr_match) begin
                state_nxt = ST_DATA;
                count_nxt = CW'(DATA_LENGTH);
                word_nxt  = '0;
                addr_nxt  = ipRxStream.Data;
                src_nxt   = ipRxStream.Source;
            end else if (hdr_bad_len) begin
                error_nxt = 1'b1;
                state_nxt = ipRxStream.EoP ? ST_IDLE : ST_DISCARD;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output decode (registered above, so strobe appears in COMMIT)
    // ------------------------------------------------------------------
    always_comb begin
        write_nxt         = (state_nxt == ST_COMMIT);
        busy_nxt          = (state_nxt == ST_COMMIT) || (state_nxt == ST_ACK);
        write_address_nxt = opWriteAddress;
        write_data_nxt    = opWriteData;
        tx_nxt            = opTxStream;

        if (write_nxt) begin
            write_address_nxt = addr_nxt;
            write_data_nxt    = word_nxt;
        end

        if ((state == ST_COMMIT) && (state_nxt == ST_ACK)) begin
            tx_nxt.Valid       = 1'b1;
            tx_nxt.SoP         = 1'b1;
            tx_nxt.EoP         = 1'b1;
            tx_nxt.Length      = 8'd1;
            tx_nxt.Source      = WRITE_DEST;
            tx_nxt.Destination = src;
            tx_nxt.Data        = addr;
        end else if ((state == ST_ACK) && ipTxReady) begin
            // Payload fields keep their values; only the framing flags drop.
            tx_nxt.Valid = 1'b0;
            tx_nxt.SoP   = 1'b0;
            tx_nxt.EoP   = 1'b0;
        end
    end

endmodule : write_controller

`default_nettype wire

// File: tb/tb_write_controller.sv
// ============================================================================
//  Module      : tb_write_controller
//  Description : Self-checking bench for write_controller. Directed scenarios
//                followed by a randomized packet mix; expected writes, error
//                pulses and acknowledge packets come from a packet-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_write_controller;
    import write_controller_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    UART_PACKET rx;
    logic       rdy_sel, rdy_man, rdy_rnd;
    logic       ready;
    UART_PACKET tx;
    logic [7:0]  waddr;
    logic [31:0] wdata;
    logic        wr, err, busy;

    assign ready = rdy_sel ? rdy_rnd : rdy_man;

    always #5 clk = ~clk;

    write_controller #(
        .WRITE_DEST  (8'h01),
        .DATA_LENGTH (4),
        .GEN_ACK     (1'b1)
    ) dut (
        .ipClk          (clk),
        .ipReset        (rst_n),
        .ipRxStream     (rx),
        .ipTxReady      (ready),
        .opTxStream     (tx),
        .opWriteAddress (waddr),
        .opWriteData    (wdata),
        .opWrite        (wr),
        .opError        (err),
        .opBusy         (busy)
    );

    // ---------------- monitor ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit [7:0]   got_addr_q[$];
    bit [31:0]  got_data_q[$];
    int         got_cyc_q[$];
    UART_PACKET got_ack_q[$];
    int err_cnt  = 0;
    int both_cnt = 0;
    int txv_cnt  = 0;

    always @(negedge clk) begin
        if (wr) begin
            got_addr_q.push_back(waddr);
            got_data_q.push_back(wdata);
            got_cyc_q.push_back(cyc);
        end
        if (err) err_cnt++;
        if (wr && err) both_cnt++;
        if (tx.Valid) txv_cnt++;
        if (tx.Valid && ready) got_ack_q.push_back(tx);
    end

    initial begin
        rdy_rnd = 1'b1;
        forever begin
            @(posedge clk);
            #2 rdy_rnd = 1'($urandom_range(1, 0));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- model / scoreboard ----------------
    int checks = 0;
    int errors = 0;
    bit [7:0]   exp_addr_q[$];
    bit [31:0]  exp_data_q[$];
    UART_PACKET exp_ack_q[$];
    int exp_err = 0;
    int base_w  = 0;
    int base_a  = 0;
    int last_cyc;
    UART_PACKET pq[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic bit [31:0] le_word(input bit [7:0] b0, b1, b2, b3);
        return 32'(b0) + (32'(b1) << 8) + (32'(b2) << 16) + (32'(b3) << 24);
    endfunction

    function automatic UART_PACKET mk(input bit [7:0] s, d, l, input bit sop, eop, input bit [7:0] data);
        UART_PACKET p;
        p.Source = s; p.Destination = d; p.Length = l;
        p.SoP = sop; p.EoP = eop; p.Valid = 1'b1; p.Data = data;
        return p;
    endfunction

    function automatic UART_PACKET junk();
        UART_PACKET p;
        p = mk(8'($urandom), 8'($urandom_range(1, 0)), 8'd5, 1'($urandom), 1'($urandom), 8'($urandom));
        p.Valid = 1'b0;
        return p;
    endfunction

    task automatic drive(input UART_PACKET p);
        @(posedge clk);
        #2 rx = p;
    endtask

    task automatic play(input int min_gap, input int max_gap);
        for (int i = 0; i < pq.size(); i++) begin
            drive(pq[i]);
            if (i == pq.size() - 1) last_cyc = cyc;
            else repeat ($urandom_range(max_gap, min_gap)) drive(junk());
        end
        drive(junk());
        pq.delete();
    endtask

    function automatic UART_PACKET ack_of(input bit [7:0] s, a);
        return mk(8'h01, s, 8'd1, 1'b1, 1'b1, a);
    endfunction

    // Queue a well-formed write and record its expected effects.
    task automatic good_pkt(input bit [7:0] s, a, b0, b1, b2, b3);
        pq.push_back(mk(s, 8'h01, 8'd5, 1'b1, 1'b0, a));
        pq.push_back(mk(s, 8'h01, 8'd5, 1'b0, 1'b0, b0));
        pq.push_back(mk(s, 8'h01, 8'd5, 1'b0, 1'b0, b1));
        pq.push_back(mk(s, 8'h01, 8'd5, 1'b0, 1'b0, b2));
        pq.push_back(mk(s, 8'h01, 8'd5, 1'b0, 1'b1, b3));
        exp_addr_q.push_back(a);
        exp_data_q.push_back(le_word(b0, b1, b2, b3));
        exp_ack_q.push_back(ack_of(s, a));
    endtask

    // Generic packet of n bytes (SoP first, EoP last) with given header.
    task automatic raw_pkt(input bit [7:0] s, d, l, input int n);
        for (int i = 0; i < n; i++)
            pq.push_back(mk(s, d, l, i == 0, i == n - 1, 8'($urandom)));
    endtask

    task automatic settle();
        int n = 0;
        repeat (2) @(negedge clk);
        while ((busy || tx.Valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("settle_bound", 64'(n < 200), 64'd1);
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_nwrites"}, 64'(got_addr_q.size()), 64'(exp_addr_q.size()));
        for (int i = base_w; i < got_addr_q.size() && i < exp_addr_q.size(); i++) begin
            check({tag, "_addr"}, 64'(got_addr_q[i]), 64'(exp_addr_q[i]));
            check({tag, "_data"}, 64'(got_data_q[i]), 64'(exp_data_q[i]));
        end
        base_w = got_addr_q.size();
        check({tag, "_nacks"}, 64'(got_ack_q.size()), 64'(exp_ack_q.size()));
        for (int i = base_a; i < got_ack_q.size() && i < exp_ack_q.size(); i++)
            check({tag, "_ack"}, 64'(got_ack_q[i]), 64'(exp_ack_q[i]));
        base_a = got_ack_q.size();
        check({tag, "_errors"}, 64'(err_cnt), 64'(exp_err));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_write"}, 64'(wr), 64'd0);
        check({tag, "_error"}, 64'(err), 64'd0);
        check({tag, "_busy"},  64'(busy), 64'd0);
        check({tag, "_waddr"}, 64'(waddr), 64'd0);
        check({tag, "_wdata"}, 64'(wdata), 64'd0);
        check({tag, "_tx"},    64'(tx), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n, kind, txv0;
        UART_PACKET exp_ack;

        rst_n   = 1'b0;
        rx      = '0;
        rdy_sel = 1'b0;
        rdy_man = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: nominal write, ready high so the ack lasts one cycle
        txv0 = txv_cnt;
        good_pkt(8'h05, 8'h10, 8'hEF, 8'hBE, 8'hAD, 8'hDE);
        play(0, 0);
        settle();
        check("t1_latency", 64'(got_cyc_q[got_cyc_q.size() - 1]), 64'(last_cyc + 1));
        check("t1_data_lit", 64'(got_data_q[got_data_q.size() - 1]), 64'h0000_0000_DEAD_BEEF);
        check("t1_ack_cycles", 64'(txv_cnt - txv0), 64'd1);
        compare_all("t1");

        // 2: back-pressure for 7 cycles
        rdy_man = 1'b0;
        good_pkt(8'h22, 8'h44, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        exp_ack = ack_of(8'h22, 8'h44);
        play(0, 0);
        n = 0;
        while (!tx.Valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t2_ack_seen", 64'(tx.Valid), 64'd1);
        for (int i = 0; i < 7; i++) begin
            check("t2_ack_hold", 64'(tx), 64'(exp_ack));
            check("t2_busy_hold", 64'(busy), 64'd1);
            if (i < 6) @(negedge clk);
        end
        @(posedge clk);
        #2 rdy_man = 1'b1;
        @(negedge clk);
        check("t2_valid_at_ready", 64'(tx.Valid), 64'd1);
        @(negedge clk);
        check("t2_valid_dropped", 64'(tx.Valid), 64'd0);
        check("t2_busy_dropped", 64'(busy), 64'd0);
        good_pkt(8'h07, 8'h45, 8'h01, 8'h23, 8'h45, 8'h67);
        play(0, 0);
        settle();
        compare_all("t2");

        // 3: short packet, then a good one
        pq.push_back(mk(8'h03, 8'h01, 8'd5, 1'b1, 1'b0, 8'h20));
        pq.push_back(mk(8'h03, 8'h01, 8'd5, 1'b0, 1'b0, 8'h11));
        pq.push_back(mk(8'h03, 8'h01, 8'd5, 1'b0, 1'b1, 8'h22));
        exp_err++;
        play(0, 0);
        settle();
        check("t3_busy", 64'(busy), 64'd0);
        good_pkt(8'h03, 8'h21, 8'h55, 8'h66, 8'h77, 8'h88);
        play(0, 0);
        settle();
        compare_all("t3");

        // 4: new SoP mid-packet restarts on the new header
        pq.push_back(mk(8'h09, 8'h01, 8'd5, 1'b1, 1'b0, 8'h30));
        pq.push_back(mk(8'h09, 8'h01, 8'd5, 1'b0, 1'b0, 8'hAA));
        pq.push_back(mk(8'h09, 8'h01, 8'd5, 1'b1, 1'b0, 8'h31));
        pq.push_back(mk(8'h09, 8'h01, 8'd5, 1'b0, 1'b0, 8'h01));
        pq.push_back(mk(8'h09, 8'h01, 8'd5, 1'b0, 1'b0, 8'h02));
        pq.push_back(mk(8'h09, 8'h01, 8'd5, 1'b0, 1'b0, 8'h03));
        pq.push_back(mk(8'h09, 8'h01, 8'd5, 1'b0, 1'b1, 8'h04));
        exp_err++;
        exp_addr_q.push_back(8'h31);
        exp_data_q.push_back(32'h0403_0201);
        exp_ack_q.push_back(ack_of(8'h09, 8'h31));
        play(0, 0);
        settle();
        compare_all("t4");

        // 5: asynchronous reset after two data bytes
        pq.push_back(mk(8'h0A, 8'h01, 8'd5, 1'b1, 1'b0, 8'h50));
        pq.push_back(mk(8'h0A, 8'h01, 8'd5, 1'b0, 1'b0, 8'h91));
        pq.push_back(mk(8'h0A, 8'h01, 8'd5, 1'b0, 1'b0, 8'h92));
        play(0, 0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_zero("t5_async");
        @(posedge clk);
        #2 rst_n = 1'b1;
        pq.push_back(mk(8'h0A, 8'h01, 8'd5, 1'b0, 1'b0, 8'h93));
        pq.push_back(mk(8'h0A, 8'h01, 8'd5, 1'b0, 1'b1, 8'h94));
        play(0, 0);
        settle();
        check("t5_no_write", 64'(wr | 1'(got_addr_q.size() != exp_addr_q.size())), 64'd0);
        good_pkt(8'h0B, 8'h51, 8'hC0, 8'hFF, 8'hEE, 8'h0D);
        play(0, 0);
        settle();
        compare_all("t5");

        // 6: foreign packet plus a gapped write, then a random mix
        raw_pkt(8'h0C, 8'h00, 8'd5, 5);
        play(0, 0);
        good_pkt(8'h0C, 8'h60, 8'h12, 8'h34, 8'h56, 8'h78);
        play(3, 3);
        settle();
        compare_all("t6_directed");

        rdy_sel = 1'b1;
        for (int it = 0; it < 30; it++) begin
            kind = int'($urandom_range(4, 0));
            case (kind)
                0, 1: good_pkt(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                               8'($urandom), 8'($urandom));
                2: raw_pkt(8'($urandom), 8'($urandom_range(255, 2)), 8'($urandom),
                           int'($urandom_range(6, 1)));
                3: begin
                    n = int'($urandom_range(8, 1));
                    if (n >= 5) n++;
                    raw_pkt(8'($urandom), 8'h01, 8'(n), int'($urandom_range(4, 1)));
                    exp_err++;
                end
                default: begin
                    raw_pkt(8'($urandom), 8'h01, 8'd5, 6);
                    pq[1].SoP = 1'b0;
                    exp_err++;
                end
            endcase
            play(0, 3);
            settle();
        end
        compare_all("t6_random");
        check("never_write_and_error", 64'(both_cnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_write_controller

`default_nettype wire

// File: doc/write_controller.md
Name: write_controller

Overview:
- Register-write endpoint of the UART packet interface; the write-side counterpart of the read controller.
- Consumes the byte-wise UART_PACKET stream from the packet deframer and extracts an 8-bit register address plus a 32-bit word.
- Issues a single-cycle write strobe to the register bank.
- Optionally returns a 1-byte acknowledge packet on the TX packet stream.

Parameters:
- WRITE_DEST, 8'h01, Destination value that selects this block.
- DATA_LENGTH, 4, Number of data bytes per write (word width = 8*DATA_LENGTH, fixed at 32 for this revision).
- GEN_ACK, 1, 1 = send acknowledge packet after each commit; 0 = no TX traffic.

Ports:
- ipClk  input  1  System clock; all logic on its rising edge.
- ipReset  input  1  Asynchronous, active-low reset.
- ipRxStream  input  UART_PACKET  Incoming stream: Source, Destination, Length, SoP, EoP, Valid, Data[7:0]. A byte is taken only on an edge where Valid=1.
- ipTxReady  input  1  TX framer accepts the current opTxStream byte on an edge where this is 1.
- opTxStream  output  UART_PACKET  Acknowledge packet stream.
- opWriteAddress  output  8  Register address.
- opWriteData  output  32  Register data.
- opWrite  output  1  One-cycle write strobe; address and data are valid in the same cycle.
- opError  output  1  One-cycle pulse when a malformed packet is discarded.
- opBusy  output  1  High in COMMIT and ACK; RX bytes are ignored while high.

Behaviour:
- Reset (ipReset=0, asynchronous):
  - state=IDLE.
  - opWrite=0, opError=0, opBusy=0.
  - opWriteAddress=0, opWriteData=0.
  - All opTxStream fields=0.
  - Byte counter and partial word cleared.
  - A reset mid-packet drops the partial word; no write is issued.
- Packet format:
  - Byte0 (SoP=1) = address.
  - Bytes 1..4 = data, little-endian: byte1->[7:0], byte2->[15:8], byte3->[23:16], byte4->[31:24].
  - Byte4 carries EoP=1.
  - Length field must be 5.
- IDLE:
  - Match = Valid & SoP & Destination==WRITE_DEST & Length==5.
  - On match: latch address, latch Source as the ack return address, counter=DATA_LENGTH, go to DATA.
  - Valid & SoP & Destination==WRITE_DEST & Length!=5: pulse opError; go to DISCARD, or stay in IDLE if EoP is also set.
  - All other bytes are ignored.
- DATA:
  - Each Valid byte shifts into the word at lane (DATA_LENGTH-counter); the counter decrements.
  - Last byte (counter==1) with EoP=1: go to COMMIT.
  - Last byte with EoP=0: opError; go to DISCARD.
  - EoP=1 before the last byte: opError; go to IDLE.
  - SoP=1 in DATA: opError; the current packet is aborted and the byte is re-evaluated as an IDLE header in the same cycle.
- DISCARD:
  - Drop bytes until Valid & EoP, then go to IDLE.
  - SoP in DISCARD behaves as in DATA.
- COMMIT:
  - One cycle: opWriteAddress/opWriteData registered, opWrite=1.
  - Latency: opWrite is asserted on the edge after the final-byte edge.
  - Then go to ACK if GEN_ACK=1, else IDLE.
- ACK:
  - opTxStream: Valid=1, SoP=1, EoP=1, Length=1, Source=WRITE_DEST, Destination=latched Source, Data=latched address.
  - Hold all fields stable until an edge with ipTxReady=1; on that edge Valid/SoP/EoP->0 and go to IDLE.
  - If ipTxReady is already high on entry, ACK lasts exactly one cycle.
- Outputs:
  - opWrite and opError are never high together.
  - opWriteAddress/opWriteData hold their last values between writes.
- Width: addresses wrap naturally at 8 bits; there is no range checking here (the register bank ignores unmapped addresses).

Test Plan:
1. Nominal write: Dest=01, Src=05, Len=5, bytes 10,EF,BE,AD,DE (EoP on DE) -> one-cycle opWrite with address 8'h10, data 32'hDEADBEEF; ack packet Dest=05, Data=10; Valid held until ipTxReady.
2. Back-pressure: ipTxReady low for 7 cycles after the ack appears -> opTxStream stable for 7 cycles, drops 1 cycle after ready; the next write is accepted afterwards.
3. Short packet: header addr 20, data 11,22 with EoP on 22 -> opError pulse, no opWrite, state IDLE; a following valid packet writes correctly.
4. New SoP mid-packet: addr 30, data AA, then new header addr 31 with data 01,02,03,04 -> one opError, then opWrite addr 31 data 32'h04030201.
5. Reset mid-packet: ipReset low after 2 data bytes -> all outputs 0 immediately (asynchronous); no write after release; the next packet is handled normally.
6. Gapped Valid / foreign destination: a packet to Dest=00 interleaved, plus Valid gaps of 3 cycles in a Dest=01 write -> the foreign packet is ignored; exactly one correct write results.
